lifo_mc: RTL
============

Name: lifo_mc

Overview:
- Multi-channel LIFO stack buffer: CH_NUM independent stacks, each DEPTH words of DATA_W bits.
- Adds to the single-channel lifo:
  - registered read data with a valid strobe
  - same-cycle push+pop (top replace / pass-through)
  - per-channel fill count
  - optional sticky error flags
- Sits between producers and consumers that need last-in-first-out ordering per channel, e.g. per-context return-address or undo stacks.

Parameters:
- CH_NUM, 4, number of independent channels (>=1)
- DEPTH, 8, words per channel stack (>=2)
- DATA_W, 16, data word width
- CNT_W, $clog2(DEPTH+1), count width per channel (derived, do not override)

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous active-high reset
- w_req  in  CH_NUM  per-channel push request
- w_data  in  CH_NUM*DATA_W  push data; channel i in bits [i*DATA_W +: DATA_W]
- r_req  in  CH_NUM  per-channel pop request
- r_data  out  CH_NUM*DATA_W  popped data, registered; channel i slice as w_data
- r_valid  out  CH_NUM  one-cycle strobe, r_data slice valid
- cnt  out  CH_NUM*CNT_W  words stored per channel, registered
- empty  out  CH_NUM  cnt==0, registered
- full  out  CH_NUM  cnt==DEPTH, registered
- err_ovf  out  CH_NUM  sticky push-when-full (only with LIFO_MC_ERR_EN)
- err_unf  out  CH_NUM  sticky pop-when-empty (only with LIFO_MC_ERR_EN)

Behaviour:
- Interface: one clock, clk; reset rst is synchronous and active-high.
- Reset values:
  - cnt=0, empty=1, full=0, r_valid=0, r_data=0, err_*=0.
  - Storage array is not reset.
  - rst dominates all same-cycle requests.
- Channels are fully independent. No shared arbitration; all channels may push and pop in the same cycle.
- Per channel, evaluated in the cycle requests are sampled. Outputs update on the next edge.
  - Push only, not full: mem[cnt] <= w_data, cnt+1.
  - Push only, full: request dropped, state unchanged.
  - Pop only, not empty: r_data <= mem[cnt-1], r_valid=1, cnt-1.
  - Pop only, empty: request ignored, r_valid=0, r_data holds previous value.
  - Push+pop, not empty (including full): r_data <= mem[cnt-1] (old top), mem[cnt-1] <= w_data, cnt unchanged, r_valid=1.
  - Push+pop, empty: pass-through, r_data <= w_data, r_valid=1, cnt stays 0.
- Latency:
  - pop to r_valid/r_data is 1 cycle.
  - push to updated cnt/empty/full is 1 cycle.
  - A pop in the cycle after a push returns the pushed word.
- r_data holds its last value when r_valid=0.
- empty/full are decoded from the next cnt value and registered, so they are coincident with cnt.
- Counts saturate: cnt never exceeds DEPTH and never underflows. No wrap-around.
- Reset mid-operation: contents are logically discarded (cnt=0). An in-flight r_valid for that cycle is suppressed.

Optional Feature:
- Macro: LIFO_MC_ERR_EN.
- Defined:
  - err_ovf[i] sets on a push-only to full channel i.
  - err_unf[i] sets on a pop-only to empty channel i.
  - Both are sticky until rst.
  - Simultaneous push+pop never sets errors.
- Undefined:
  - err_ovf/err_unf ports are absent.
  - No flag logic is synthesised.
  - Drop/ignore behaviour is unchanged.

Decomposition:
- Package lifo_mc_pkg holds:
  - function for CNT_W derivation
  - enum op_t {OP_NONE, OP_PUSH, OP_POP, OP_REPLACE} used to decode {w_req,r_req} per channel
- Sub-module lifo_ch: one channel (storage, cnt, flags, registered read), instantiated CH_NUM times via generate.
- Top lifo_mc only slices the buses and wires macro-dependent ports.

Test Plan:
- Reset then idle, CH_NUM=4 DEPTH=8 DATA_W=16 -> all empty=1, full=0, cnt=0, r_valid=0.
- Ch0 push 0x0001..0x0008 on 8 consecutive cycles, then 9th push 0xDEAD -> full[0]=1, cnt=8, 0xDEAD dropped. With LIFO_MC_ERR_EN, err_ovf[0]=1.
- Ch0 then pops 9 times -> r_data 0x0008,0x0007..0x0001 each with r_valid, one cycle after each pop. 9th pop gives r_valid=0, r_data holds 0x0001, empty=1. With LIFO_MC_ERR_EN, err_unf[0]=1.
- Ch1:
  - holding 0x00AA, push 0x00BB + pop same cycle -> r_data=0x00AA, cnt stays 1.
  - next pop -> r_data=0x00BB.
  - empty push 0x1234 + pop -> r_data=0x1234, cnt=0.
- All 4 channels push/pop random per-channel patterns concurrently for 10k cycles -> each channel matches an independent reference stack model. No cross-channel corruption.
- Ch2 holding 5 words, rst asserted same cycle as a pop -> r_valid=0, cnt=0, empty=1. Next push/pop pair returns the newly pushed word.

Source files
------------

// File: rtl/lifo_mc_pkg.sv
// Shared types and helpers for the multi-channel LIFO: count-width derivation
// and per-channel request decode.
package lifo_mc_pkg;

    typedef enum logic [1:0] {
        OP_NONE,
        OP_PUSH,
        OP_POP,
        OP_REPLACE
    } op_t;

    function automatic int unsigned cnt_w_f(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

    function automatic op_t op_decode(input logic w, input logic r);
        op_t op;
        case ({w, r})
            2'b10:   op = OP_PUSH;
            2'b01:   op = OP_POP;
            2'b11:   op = OP_REPLACE;
            default: op = OP_NONE;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/lifo_ch.sv
// One LIFO channel: storage, fill count, registered read port, and
// (with LIFO_MC_ERR_EN) sticky overflow/underflow flags.
module lifo_ch
    import lifo_mc_pkg::*;
#(
    parameter int unsigned DEPTH  = 8,
    parameter int unsigned DATA_W = 16,
    parameter int unsigned CNT_W  = cnt_w_f(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              w_req,
    input  logic [DATA_W-1:0] w_data,
    input  logic              r_req,
    output logic [DATA_W-1:0] r_data,
    output logic              r_valid,
    output logic [CNT_W-1:0]  cnt,
    output logic              empty,
    output logic              full
`ifdef LIFO_MC_ERR_EN
    ,
    output logic              err_ovf,
    output logic              err_unf
`endif
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DATA_W-1:0] mem [DEPTH];

    op_t              op;
    logic [CNT_W-1:0] cnt_nxt;
    logic [AW-1:0]    top_idx;
    logic [AW-1:0]    wr_idx;
    logic             mem_we;
    logic             rd_vld;
    logic             rd_pass;
`ifdef LIFO_MC_ERR_EN
    logic             ovf_set;
    logic             unf_set;
`endif

    // Decode this cycle's request into storage/count/read actions.
    always_comb begin
        op      = op_decode(w_req, r_req);
        top_idx = AW'(cnt - CNT_W'(1));
        cnt_nxt = cnt;
        wr_idx  = top_idx;
        mem_we  = 1'b0;
        rd_vld  = 1'b0;
        rd_pass = 1'b0;
`ifdef LIFO_MC_ERR_EN
        ovf_set = 1'b0;
        unf_set = 1'b0;
`endif
        case (op)
            OP_PUSH: begin
                if (!full) begin
                    mem_we  = 1'b1;
                    wr_idx  = AW'(cnt);
                    cnt_nxt = cnt + CNT_W'(1);
                end
`ifdef LIFO_MC_ERR_EN
                else ovf_set = 1'b1;
`endif
            end
            OP_POP: begin
                if (!empty) begin
                    rd_vld  = 1'b1;
                    cnt_nxt = cnt - CNT_W'(1);
                end
`ifdef LIFO_MC_ERR_EN
                else unf_set = 1'b1;
`endif
            end
            OP_REPLACE: begin
                rd_vld = 1'b1;
                if (empty) rd_pass = 1'b1;
                else       mem_we  = 1'b1;
            end
            default: ;
        endcase
    end

    // Storage is intentionally not reset; cnt alone defines valid contents.
    always_ff @(posedge clk) begin
        if (mem_we && !rst) mem[wr_idx] <= w_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt     <= '0;
            empty   <= 1'b1;
            full    <= 1'b0;
            r_valid <= 1'b0;
            r_data  <= '0;
`ifdef LIFO_MC_ERR_EN
            err_ovf <= 1'b0;
            err_unf <= 1'b0;
`endif
        end else begin
            cnt     <= cnt_nxt;
            empty   <= (cnt_nxt == '0);
            full    <= (cnt_nxt == CNT_W'(DEPTH));
            r_valid <= rd_vld;
            if (rd_vld) r_data <= rd_pass ? w_data : mem[top_idx];
`ifdef LIFO_MC_ERR_EN
            err_ovf <= err_ovf | ovf_set;
            err_unf <= err_unf | unf_set;
`endif
        end
    end

endmodule

// File: rtl/lifo_mc.sv
// Multi-channel LIFO top: CH_NUM independent lifo_ch stacks on sliced buses.
// Sticky error ports exist only when LIFO_MC_ERR_EN is defined.
module lifo_mc
    import lifo_mc_pkg::*;
#(
    parameter int unsigned CH_NUM = 4,
    parameter int unsigned DEPTH  = 8,
    parameter int unsigned DATA_W = 16,
    parameter int unsigned CNT_W  = cnt_w_f(DEPTH)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [CH_NUM-1:0]        w_req,
    input  logic [CH_NUM*DATA_W-1:0] w_data,
    input  logic [CH_NUM-1:0]        r_req,
    output logic [CH_NUM*DATA_W-1:0] r_data,
    output logic [CH_NUM-1:0]        r_valid,
    output logic [CH_NUM*CNT_W-1:0]  cnt,
    output logic [CH_NUM-1:0]        empty,
    output logic [CH_NUM-1:0]        full
`ifdef LIFO_MC_ERR_EN
    ,
    output logic [CH_NUM-1:0]        err_ovf,
    output logic [CH_NUM-1:0]        err_unf
`endif
);

    for (genvar i = 0; i < int'(CH_NUM); i++) begin : g_ch
        lifo_ch #(
            .DEPTH  (DEPTH),
            .DATA_W (DATA_W),
            .CNT_W  (CNT_W)
        ) u_ch (
            .clk     (clk),
            .rst     (rst),
            .w_req   (w_req[i]),
            .w_data  (w_data[i*DATA_W +: DATA_W]),
            .r_req   (r_req[i]),
            .r_data  (r_data[i*DATA_W +: DATA_W]),
            .r_valid (r_valid[i]),
            .cnt     (cnt[i*CNT_W +: CNT_W]),
            .empty   (empty[i]),
            .full    (full[i])
`ifdef LIFO_MC_ERR_EN
            ,
            .err_ovf (err_ovf[i]),
            .err_unf (err_unf[i])
`endif
        );
    end

endmodule
